// File: rtl/script_pkg.sv
// Shared definitions for the script sequencer: script word layout, opcodes
// and FSM state encoding.
package script_pkg;

  localparam int WORD_WIDTH  = 36;

  localparam int PAYLOAD_MSB = 35;
  localparam int PAYLOAD_LSB = 18;
  localparam int OPCODE_MSB  = 17;
  localparam int OPCODE_LSB  = 16;
  localparam int COUNT_MSB   = 15;
  localparam int COUNT_LSB   = 0;

  localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;
  localparam int OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int COUNT_W     = COUNT_MSB - COUNT_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_CMD   = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_WAITF = 2'b01;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 2'b10;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 2'b11;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH      = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISSUE      = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_LINE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_FRAME = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALTED     = 3'd6;

  function automatic logic [PAYLOAD_W-1:0] word_payload(input logic [WORD_WIDTH-1:0] w);
    return w[PAYLOAD_MSB:PAYLOAD_LSB];
  endfunction

  function automatic logic [OPCODE_W-1:0] word_opcode(input logic [WORD_WIDTH-1:0] w);
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [COUNT_W-1:0] word_count(input logic [WORD_WIDTH-1:0] w);
    return w[COUNT_MSB:COUNT_LSB];
  endfunction

  function automatic logic state_is_busy(input logic [STATE_W-1:0] s);
    return (s != ST_IDLE) && (s != ST_HALTED);
  endfunction

endpackage

// File: rtl/script_wait_counter.sv
// Loadable down-counter used to pace CMD and WAITF words by line/frame events.
// done_o is combinational so the sequencer can leave a wait on the final event.
module script_wait_counter #(
  parameter int WAIT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [WAIT_WIDTH-1:0] load_value_i,
  input  logic                  event_i,
  output logic                  done_o
);

  logic [WAIT_WIDTH-1:0] count_q;
  logic [WAIT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (event_i && (count_q != '0)) begin
      count_d = count_q - WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0) || ((count_q == WAIT_WIDTH'(1)) && event_i);

endmodule

// File: rtl/script_sequencer.sv
// Fetches 36-bit script words from a 1-cycle-latency ROM and either issues
// commands over valid/ready or pauses for line/frame events; supports jump/halt.
module script_sequencer
  import script_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int CMD_WIDTH  = 18,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  line_end,
  input  logic                  frame_end,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WORD_WIDTH-1:0] rom_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  output logic                  busy,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CMD_WIDTH-1:0]  cmd_data_q, cmd_data_d;
  logic                  stop_pend_q, stop_pend_d;

  logic [PAYLOAD_W-1:0]  payload;
  logic [OPCODE_W-1:0]   opcode;
  logic [COUNT_W-1:0]    count_field;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [WAIT_WIDTH-1:0] cnt_value;
  logic                  cnt_load;
  logic                  cnt_event;
  logic                  cnt_done;
  logic                  handshake;

  assign payload     = word_payload(rom_data);
  assign opcode      = word_opcode(rom_data);
  assign count_field = word_count(rom_data);
  assign cnt_value   = WAIT_WIDTH'(count_field);
  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign handshake   = cmd_valid_q && cmd_ready;

  script_wait_counter #(
    .WAIT_WIDTH(WAIT_WIDTH)
  ) u_wait_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (cnt_load),
    .load_value_i(cnt_value),
    .event_i     (cnt_event),
    .done_o      (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    stop_pend_d = stop_pend_q;
    cnt_load    = 1'b0;
    cnt_event   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = stop ? ST_IDLE : ST_DECODE;
      end

      ST_DECODE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          case (opcode)
            OP_CMD: begin
              cmd_data_d  = CMD_WIDTH'(payload);
              cmd_valid_d = 1'b1;
              cnt_load    = 1'b1;
              state_d     = ST_ISSUE;
            end
            OP_WAITF: begin
              cnt_load = 1'b1;
              state_d  = ST_WAIT_FRAME;
            end
            OP_JUMP: begin
              pc_d    = ADDR_WIDTH'(payload);
              state_d = ST_FETCH;
            end
            default: begin
              state_d = ST_HALTED;
            end
          endcase
        end
      end

      // A stop seen while a command is outstanding must not tear down the handshake;
      // it is remembered and honoured once the consumer has taken the word.
      ST_ISSUE: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (handshake) begin
          cmd_valid_d = 1'b0;
          stop_pend_d = 1'b0;
          if (stop || stop_pend_q) begin
            state_d = ST_IDLE;
          end else if (cnt_done) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WAIT_LINE;
          end
        end
      end

      ST_WAIT_LINE: begin
        cnt_event = line_end;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end

      ST_WAIT_FRAME: begin
        cnt_event = frame_end;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end

      ST_HALTED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        cmd_valid_d = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = state_is_busy(state_q);
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_script_sequencer.sv
// Bench for script_sequencer: directed timing scenarios plus random scripts
// compared against an instruction-level model of the script.
module tb_script_sequencer;
  import script_pkg::*;

  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_n, start, stop, line_end, frame_end, cmd_ready;
  logic [AW-1:0] rom_addr, pc;
  logic [35:0]   rom_data;
  logic          cmd_valid, busy, halted;
  logic [17:0]   cmd_data;
  logic [35:0]   rom [0:511];

  always @(posedge clk) rom_data <= rom[rom_addr];

  script_sequencer #(.ADDR_WIDTH(AW), .CMD_WIDTH(18), .WAIT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .line_end(line_end), .frame_end(frame_end),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .busy(busy), .halted(halted), .pc(pc)
  );

  logic        start2, stop2, ready2;
  logic [1:0]  rom_addr2, pc2;
  logic [35:0] rom_data2;
  logic        cmd_valid2, busy2, halted2;
  logic [17:0] cmd_data2;
  logic [35:0] rom2 [0:3];

  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  script_sequencer #(.ADDR_WIDTH(2), .CMD_WIDTH(18), .WAIT_WIDTH(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(stop2),
    .line_end(line_end), .frame_end(frame_end),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .cmd_valid(cmd_valid2), .cmd_ready(ready2), .cmd_data(cmd_data2),
    .busy(busy2), .halted(halted2), .pc(pc2)
  );

  logic [17:0] hs2_data [$];
  int          hs2_cyc  [$];
  always @(negedge clk) begin
    if (cmd_valid2 && ready2) begin
      hs2_data.push_back(cmd_data2);
      hs2_cyc.push_back(cyc);
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk(input logic [1:0] op, input logic [17:0] pl, input logic [15:0] cnt);
    return {pl, op, cnt};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pc_seq [$];
    logic [AW-1:0] last_pc;
    logic          busy_dropped;
    logic [17:0]   exp_q [$];
    int            halt_addr;

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; line_end = 1'b0; frame_end = 1'b0;
    cmd_ready = 1'b0; start2 = 1'b0; stop2 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = mk(OP_HALT, 18'h0, 16'h0);
    for (int i = 0; i < 4; i++) rom2[i] = mk(OP_CMD, 18'h100 + 18'(i), 16'h0);
    repeat (3) tick();

    check_eq("rst_valid", cmd_valid, 1'b0);
    check_eq("rst_data", cmd_data, 18'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_pc", pc, 9'h0);
    reset_n = 1'b1;
    tick();

    // Single command then halt: 2-cycle latency, one-cycle valid.
    rom[0] = mk(OP_CMD, 18'h2A5A3, 16'd0);
    rom[1] = mk(OP_HALT, 18'h0, 16'd0);
    cmd_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("t1_busy_fetch", busy, 1'b1);
    check_eq("t1_addr_fetch", rom_addr, 9'd0);
    tick();
    check_eq("t1_no_valid_decode", cmd_valid, 1'b0);
    tick();
    check_eq("t1_valid", cmd_valid, 1'b1);
    check_eq("t1_data", cmd_data, 18'h2A5A3);
    tick();
    check_eq("t1_valid_one_cycle", cmd_valid, 1'b0);
    check_eq("t1_pc_next", pc, 9'd1);
    tick(); tick();
    check_eq("t1_halted", halted, 1'b1);
    check_eq("t1_busy_halted", busy, 1'b0);
    check_eq("t1_pc_halted", pc, 9'd1);

    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("halt_stop_idle", halted, 1'b0);

    // CMD count 3: wait for three line_ends, frame_end ignored.
    rom[0] = mk(OP_CMD, 18'h01234, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check_eq("t2_wait_valid", cmd_valid, 1'b0);
    check_eq("t2_wait_busy", busy, 1'b1);
    repeat (5) begin
      frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
    end
    check_eq("t2_frame_ignored", rom_addr, 9'd0);
    line_end = 1'b1; tick(); line_end = 1'b0; tick();
    line_end = 1'b1; frame_end = 1'b1; tick(); line_end = 1'b0; frame_end = 1'b0; tick();
    check_eq("t2_after_two_lines", rom_addr, 9'd0);
    line_end = 1'b1; tick(); line_end = 1'b0;
    check_eq("t2_fetch_after_third", rom_addr, 9'd1);
    check_eq("t2_busy_fetch", busy, 1'b1);
    tick(); tick();
    check_eq("t2_halted", halted, 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Back-pressure with a deferred stop.
    rom[0] = mk(OP_CMD, 18'h3C0F0, 16'd0);
    cmd_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check_eq("t3_valid", cmd_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stop = (i == 3);
      tick();
      stop = 1'b0;
      check_eq("t3_hold_valid", cmd_valid, 1'b1);
      check_eq("t3_hold_data", cmd_data, 18'h3C0F0);
    end
    check_eq("t3_stop_deferred", busy, 1'b1);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    check_eq("t3_idle_busy", busy, 1'b0);
    check_eq("t3_idle_halted", halted, 1'b0);
    check_eq("t3_idle_pc", pc, 9'd0);
    check_eq("t3_idle_valid", cmd_valid, 1'b0);

    // WAITF 2 / JUMP 0 loop.
    rom[0] = mk(OP_WAITF, 18'h0, 16'd2);
    rom[1] = mk(OP_JUMP, 18'h0, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    pc_seq.push_back(pc);
    last_pc = pc;
    busy_dropped = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      line_end  = (k % 3 == 0);
      frame_end = (k == 10 || k == 20 || k == 30 || k == 40);
      tick();
      line_end = 1'b0; frame_end = 1'b0;
      if (pc !== last_pc) begin
        pc_seq.push_back(pc);
        last_pc = pc;
      end
      if (busy !== 1'b1) busy_dropped = 1'b1;
      if (k == 19) check_eq("t4_pc_before_2nd_frame", pc, 9'd0);
      if (k == 20) check_eq("t4_pc_after_2nd_frame", pc, 9'd1);
    end
    check_eq("t4_busy_held", busy_dropped, 1'b0);
    check_eq("t4_pc_changes", pc_seq.size(), 4);
    if (pc_seq.size() >= 4) begin
      check_eq("t4_seq0", pc_seq[0], 9'd0);
      check_eq("t4_seq1", pc_seq[1], 9'd1);
      check_eq("t4_seq2", pc_seq[2], 9'd0);
      check_eq("t4_seq3", pc_seq[3], 9'd1);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("t4_stop_idle", busy, 1'b0);
    check_eq("t4_stop_pc_kept", pc, 9'd1);

    // 2-bit address instance: wrap 3->0 with back-to-back commands.
    ready2 = 1'b1;
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (30) tick();
    stop2 = 1'b1; tick(); stop2 = 1'b0;
    tick(); tick();
    ready2 = 1'b0;
    check_eq("t5_idle", busy2, 1'b0);
    check_eq("t5_enough_cmds", hs2_data.size() >= 8, 1'b1);
    if (hs2_data.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        check_eq("t5_wrap_data", hs2_data[i], 18'h100 + 18'(i % 4));
      for (int i = 0; i < 7; i++)
        check_eq("t5_period", hs2_cyc[i+1] - hs2_cyc[i], 3);
    end

    // Asynchronous reset during WAIT_LINE.
    rom[0] = mk(OP_JUMP, 18'd5, 16'd0);
    rom[5] = mk(OP_CMD, 18'h2BEEF, 16'd5);
    cmd_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check_eq("t6_wait_busy", busy, 1'b1);
    check_eq("t6_wait_pc", pc, 9'd5);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_arst_busy", busy, 1'b0);
    check_eq("t6_arst_pc", pc, 9'd0);
    check_eq("t6_arst_valid", cmd_valid, 1'b0);
    check_eq("t6_arst_data", cmd_data, 18'h0);
    #2 reset_n = 1'b1;
    tick();

    // Asynchronous reset during ISSUE.
    cmd_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check_eq("t6_issue_valid", cmd_valid, 1'b1);
    check_eq("t6_issue_pc", pc, 9'd5);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_arst2_valid", cmd_valid, 1'b0);
    check_eq("t6_arst2_data", cmd_data, 18'h0);
    check_eq("t6_arst2_pc", pc, 9'd0);
    check_eq("t6_arst2_busy", busy, 1'b0);
    check_eq("t6_arst2_halted", halted, 1'b0);
    #2 reset_n = 1'b1;
    tick();

    // Random scripts against an instruction-level model.
    for (int p = 0; p < 16; p++) begin
      int len, mpc, idx, steps;
      logic hs, pv;
      logic [17:0] d;
      len = 4 + int'($urandom % 9);
      for (int i = 0; i < len - 1; i++) begin
        int r;
        r = int'($urandom % 10);
        if (r < 5 || (r >= 7 && r < 9 && i >= len - 2) || r == 9)
          rom[i] = mk(OP_CMD, 18'($urandom), 16'($urandom % 4));
        else if (r < 7)
          rom[i] = mk(OP_WAITF, 18'h0, 16'($urandom % 3));
        else
          rom[i] = mk(OP_JUMP, 18'(i + 1 + int'($urandom % (len - 1 - i))), 16'h0);
      end
      rom[len - 1] = mk(OP_HALT, 18'h0, 16'h0);

      exp_q.delete();
      mpc = 0;
      steps = 0;
      while (rom[mpc][17:16] != OP_HALT && steps < 64) begin
        steps++;
        if (rom[mpc][17:16] == OP_CMD) begin
          exp_q.push_back(rom[mpc][35:18]);
          mpc = mpc + 1;
        end else if (rom[mpc][17:16] == OP_WAITF) begin
          mpc = mpc + 1;
        end else begin
          mpc = int'(rom[mpc][35:18]);
        end
      end
      halt_addr = mpc;

      start = 1'b1; tick(); start = 1'b0;
      idx = 0;
      for (int c = 0; c < 1500 && !halted; c++) begin
        cmd_ready = 1'($urandom % 2);
        line_end  = ($urandom % 3 == 0);
        frame_end = ($urandom % 3 == 0);
        hs = cmd_valid && cmd_ready;
        pv = cmd_valid;
        d  = cmd_data;
        tick();
        if (hs) begin
          if (idx < exp_q.size()) check_eq("rnd_cmd", d, exp_q[idx]);
          idx++;
        end else if (pv) begin
          check_eq("rnd_hold", {cmd_valid, cmd_data}, {1'b1, d});
        end
      end
      cmd_ready = 1'b0; line_end = 1'b0; frame_end = 1'b0;
      check_eq("rnd_halted", halted, 1'b1);
      check_eq("rnd_halt_pc", pc, 9'(halt_addr));
      check_eq("rnd_cmd_count", idx, exp_q.size());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
